// File: rtl/bas_pkg.sv
// Shared definitions for the BAS result monitor: BF16 special encodings,
// the run-control state enum and the result-cause encoding.
package bas_pkg;

    localparam logic [15:0] POS_INF  = 16'h7F80;
    localparam logic [15:0] POS_ZERO = 16'h0000;
    localparam logic [15:0] NEG_ZERO = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        CAUSE_BUDGET = 2'b00,
        CAUSE_TARGET = 2'b01,
        CAUSE_STALL  = 2'b10
    } res_cause_t;

    // True for NaN or +/-Inf: the exponent field is all ones.
    function automatic logic bf16_nonfinite(input logic [15:0] v);
        return (v[14:7] == 8'hFF);
    endfunction

endpackage

// File: rtl/bf16_cmp.sv
// BF16 comparator using sign-magnitude ordering. -0 and +0 compare equal.
// Any NaN operand makes both orderings false.
module bf16_cmp
    import bas_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        a_lt_b,
    output logic        a_le_b,
    output logic        a_is_nan,
    output logic        a_is_inf
);

    logic        b_is_nan;
    logic        both_zero;
    logic        any_nan;
    logic [15:0] a_key;
    logic [15:0] b_key;

    assign a_is_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    assign a_is_inf = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    assign b_is_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    assign any_nan  = a_is_nan | b_is_nan;

    assign both_zero = ((a == POS_ZERO) || (a == NEG_ZERO)) &&
                       ((b == POS_ZERO) || (b == NEG_ZERO));

    // Map sign-magnitude onto an unsigned key whose order is the numeric order:
    // negatives are bit-inverted, positives get the top bit set.
    assign a_key = a[15] ? ~a : {1'b1, a[14:0]};
    assign b_key = b[15] ? ~b : {1'b1, b[14:0]};

    // Zero pair is forced equal; otherwise the keys decide.
    always_comb begin
        a_lt_b = 1'b0;
        a_le_b = 1'b0;
        if (!any_nan) begin
            if (both_zero) begin
                a_le_b = 1'b1;
            end else begin
                a_lt_b = (a_key <  b_key);
                a_le_b = (a_key <= b_key);
            end
        end
    end

endmodule

// File: rtl/bas_result_monitor.sv
// Tracks the best (minimum-fitness) BF16 sample of a BAS run and reports
// why the run stopped: target reached, stall limit, or iteration budget.
// Optional build macro BAS_MON_NAN_FILTER_EN drops non-finite samples and
// adds the nan_cnt output.
module bas_result_monitor
    import bas_pkg::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int ITER_W      = 16
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       target,
    input  logic              in_valid,
    input  logic [15:0]       in_x,
    input  logic [15:0]       in_y,
    input  logic [15:0]       in_f,
    input  logic              in_last,
    output logic [15:0]       best_x,
    output logic [15:0]       best_y,
    output logic [15:0]       best_f,
    output logic [ITER_W-1:0] best_iter,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_cause,
    output logic              busy
`ifdef BAS_MON_NAN_FILTER_EN
    ,
    output logic [7:0]        nan_cnt
`endif
);

    localparam logic [ITER_W-1:0] ITER_MAX  = '1;
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [16:0]       STALL_LIM = 17'(STALL_LIMIT);

    mon_state_t        state_reg;
    logic [15:0]       best_x_reg;
    logic [15:0]       best_y_reg;
    logic [15:0]       best_f_reg;
    logic [ITER_W-1:0] best_iter_reg;
    logic [ITER_W-1:0] iter_reg;
    logic [15:0]       stall_reg;
    logic              res_valid_reg;
    res_cause_t        res_cause_reg;
    logic              busy_reg;

    logic f_lt_best, best_le, f_is_nan, f_is_inf;
    logic tgt_lt, f_le_target, tgt_nan, tgt_inf;

    logic       drop;
    logic       sample;
    logic       improve;
    logic       target_hit;
    logic       stall_hit;
    logic       done;
    res_cause_t cause_next;

    // Candidate fitness against the best so far.
    bf16_cmp u_best_cmp (
        .a        (in_f),
        .b        (best_f_reg),
        .a_lt_b   (f_lt_best),
        .a_le_b   (best_le),
        .a_is_nan (f_is_nan),
        .a_is_inf (f_is_inf)
    );

    // Candidate fitness against the goal.
    bf16_cmp u_tgt_cmp (
        .a        (in_f),
        .b        (target),
        .a_lt_b   (tgt_lt),
        .a_le_b   (f_le_target),
        .a_is_nan (tgt_nan),
        .a_is_inf (tgt_inf)
    );

`ifdef BAS_MON_NAN_FILTER_EN
    logic [7:0] nan_cnt_reg;
    logic       unused_cmp;

    assign drop       = in_valid & (bf16_nonfinite(in_x) | bf16_nonfinite(in_y) |
                                    f_is_nan | f_is_inf);
    assign nan_cnt    = nan_cnt_reg;
    assign unused_cmp = &{1'b0, best_le, tgt_lt, tgt_nan, tgt_inf};
`else
    logic unused_cmp;

    assign drop       = 1'b0;
    assign unused_cmp = &{1'b0, best_le, tgt_lt, tgt_nan, tgt_inf, f_is_inf};
`endif

    assign sample     = in_valid & ~drop;
    assign improve    = sample & f_lt_best & ~f_is_nan;
    assign target_hit = sample & f_le_target;
    assign stall_hit  = sample & ~improve & (({1'b0, stall_reg} + 17'd1) == STALL_LIM);
    assign done       = target_hit | stall_hit | in_last;

    // Termination cause with priority target > stall > budget.
    always_comb begin
        cause_next = CAUSE_BUDGET;
        if (target_hit)
            cause_next = CAUSE_TARGET;
        else if (stall_hit)
            cause_next = CAUSE_STALL;
    end

    // Run-control FSM; start (outside HOLD) clears history, termination parks results in HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            best_x_reg    <= '0;
            best_y_reg    <= '0;
            best_f_reg    <= '0;
            best_iter_reg <= '0;
            iter_reg      <= '0;
            stall_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_cause_reg <= CAUSE_BUDGET;
            busy_reg      <= 1'b0;
`ifdef BAS_MON_NAN_FILTER_EN
            nan_cnt_reg   <= '0;
`endif
        end else if (start && (state_reg != ST_HOLD)) begin
            // Fresh run; any same-cycle sample is discarded.
            state_reg     <= ST_TRACK;
            best_x_reg    <= POS_ZERO;
            best_y_reg    <= POS_ZERO;
            best_f_reg    <= POS_INF;
            best_iter_reg <= '0;
            iter_reg      <= '0;
            stall_reg     <= '0;
            busy_reg      <= 1'b1;
`ifdef BAS_MON_NAN_FILTER_EN
            nan_cnt_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                ST_TRACK: begin
                    if (sample) begin
                        if (iter_reg != ITER_MAX)
                            iter_reg <= iter_reg + ITER_ONE;
                        if (improve) begin
                            best_x_reg    <= in_x;
                            best_y_reg    <= in_y;
                            best_f_reg    <= in_f;
                            best_iter_reg <= iter_reg;
                            stall_reg     <= '0;
                        end else begin
                            stall_reg <= stall_reg + 16'd1;
                        end
                    end
`ifdef BAS_MON_NAN_FILTER_EN
                    if (drop && (nan_cnt_reg != 8'hFF))
                        nan_cnt_reg <= nan_cnt_reg + 8'd1;
`endif
                    if (done) begin
                        state_reg     <= ST_HOLD;
                        res_valid_reg <= 1'b1;
                        res_cause_reg <= cause_next;
                        busy_reg      <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        state_reg     <= ST_IDLE;
                        res_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign best_x    = best_x_reg;
    assign best_y    = best_y_reg;
    assign best_f    = best_f_reg;
    assign best_iter = best_iter_reg;
    assign res_valid = res_valid_reg;
    assign res_cause = res_cause_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/bas_result_monitor.md
BAS_RESULT_MONITOR -- requirements
Module: bas_result_monitor

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 16: the number of consecutive non-improving samples that declares convergence (legal range 1..65535).
REQ-002 SHALL have parameter ITER_W, default 16: the width of the iteration index.
REQ-003 SHALL have port clk, input, 1: rising-edge clock, the sole clock.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that clears history and begins a run.
REQ-006 SHALL have port target, input, 16: BF16 fitness goal; a sample with fitness <= target ends the run.
REQ-007 SHALL have ports in_valid (input, 1) and in_x, in_y, in_f (input, 16 each): one BF16 BAS iteration sample per cycle with in_valid high.
REQ-008 SHALL have port in_last, input, 1: upstream BAS iteration budget exhausted (its done).
REQ-009 SHALL have ports best_x, best_y, best_f, output, 16 each: best-so-far point and fitness.
REQ-010 SHALL have port best_iter, output, ITER_W: sample index at which the best was found.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_cause (output, 2; 00 budget, 01 target, 10 stall).
REQ-012 SHALL have port busy, output, 1: high while in TRACK.

Function
REQ-013 SHALL implement states IDLE, TRACK and HOLD; in IDLE, in_valid and in_last are ignored, and start moves the block to TRACK.
REQ-014 On start, SHALL set best_f=0x7F80 (+Inf), best_x=best_y=0, best_iter=0, iteration index=0 and stall=0.
REQ-015 In TRACK, each in_valid sample SHALL increment the iteration index, saturating at all-ones with no wrap-around.
REQ-016 A sample SHALL count as an improvement iff in_f < best_f strictly, by BF16 sign-magnitude ordering, with -0 equal to +0 (minimisation).
REQ-017 On improvement, SHALL latch in_x, in_y and in_f, set best_iter to the pre-increment index and clear stall; otherwise SHALL increment stall.
REQ-018 A NaN in_f (exponent all ones, mantissa nonzero) SHALL never improve and SHALL count as non-improving.
REQ-019 SHALL evaluate termination on the same sample with priority target > stall > budget:
  - target: in_valid and in_f <= target;
  - stall: stall+1 == STALL_LIMIT on a non-improving sample;
  - budget: in_last high, with or without in_valid.
REQ-020 On termination, SHALL enter HOLD on the next edge with res_valid=1, res_cause set, and best_* already including the terminating sample (latency 1 cycle).
REQ-021 In HOLD, best_* and res_cause SHALL stay stable, in_valid and start SHALL be ignored, and res_valid SHALL stay high until res_valid&res_ready, then the block SHALL go to IDLE.
REQ-022 start during TRACK SHALL restart the run (clear per REQ-014, stay in TRACK) and SHALL discard any same-cycle sample.
REQ-023 busy SHALL be 1 exactly in TRACK.

Reset
REQ-024 reset_n low SHALL immediately force IDLE and best_x=best_y=best_f=0, best_iter=0, res_valid=0, res_cause=00, busy=0, nan_cnt=0, stall=0 and iteration index=0, regardless of state.

Configuration
REQ-025 With BAS_MON_NAN_FILTER_EN defined:
  - a sample whose in_x, in_y or in_f is NaN or Inf SHALL be dropped, with no index, stall or best update and no target check;
  - the block SHALL provide output nan_cnt (8 bits), counting dropped samples, saturating at 255 and cleared on start.
  Without the macro, nan_cnt SHALL be absent and REQ-018 SHALL apply.

Structure
REQ-026 Package bas_pkg SHALL hold the BF16 constants (POS_INF 0x7F80, POS_ZERO, NEG_ZERO), the state enum and the res_cause encoding.
REQ-027 SHALL instantiate sub-module bf16_cmp (outputs a_lt_b, a_le_b, a_is_nan, a_is_inf) twice: best compare and target compare.

Verification
REQ-028 target=0xBF80; f=0x4000, 0x3F80, 0x3F00 with in_last on the third -> next cycle res_valid=1, best_f=0x3F00, best_iter=2, cause=00.
REQ-029 STALL_LIMIT=4, target=0xBF80; f=0x3F80 then 4x 0x4000 -> res_valid after the 4th, cause=10, best_f=0x3F80, best_iter=0.
REQ-030 target=0x3F80; f=0x3F80 with in_last -> cause=01 (priority); f=0x8000 then 0x0000 -> second sample is not an improvement.
REQ-031 res_ready low for 10 cycles with in_valid toggling -> outputs frozen; then res_ready=1 -> IDLE, busy=0; start in the same HOLD window is ignored.
REQ-032 reset_n pulsed low between edges mid-TRACK -> all outputs 0 before the next edge; start after release runs normally.
REQ-033 f=0x7FC0: with the macro -> nan_cnt=1, index and stall unchanged; without the macro -> stall+1, best unchanged.
